mpu_op_scheduler: RTL
=====================

# mpu_op_scheduler

Two-port arbiter and sequencer that shares the single matrix-operations datapath (200-bit operands, 3-bit opcode, size and factor inputs) between two independent requesters, such as the HPS PIO loader and a local test/DMA engine. It grants one request at a time, captures that requester's operands into holding registers, drives them to the datapath for a fixed latency, then returns the 200-bit result with a one-cycle done pulse. It sits between the requester front-ends and the operations datapath; requesters never drive the datapath directly.

## Interface
Parameters:
- N_BITS, 200: operand/result width (25 bytes of 8-bit signed elements).
- EXEC_CYCLES, 8: cycles the datapath inputs are held stable before the result is sampled; legal range 1..255.

Ports:
- clock  in  1  single clock; all logic on its rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- req_0, req_1  in  1 each  request level from requester 0 / 1.
- op_0, op_1  in  3 each  opcode for the request.
- size_sel_0, size_sel_1  in  1 each  1 = 2x2 matrix, 0 = 3x3 matrix.
- a_0, a_1  in  N_BITS each  operand A.
- b_0, b_1  in  N_BITS each  operand B.
- grant_0, grant_1  out  1 each  one-cycle pulse; operands were captured at the previous edge.
- done_0, done_1  out  1 each  one-cycle pulse; result_x is valid from this cycle.
- result_0, result_1  out  N_BITS each  last result for that requester; held until its next done.
- busy  out  1  high whenever state is not IDLE.
- dp_operation  out  3  to the datapath opcode.
- dp_matrix_a, dp_matrix_b  out  N_BITS each  to the datapath operands.
- dp_size  out  8  8'd2 when the captured size_sel = 1, else 8'd3.
- dp_factor  out  8  always dp_matrix_b[7:0].
- dp_result  in  N_BITS  datapath result.

## Operation
- States: IDLE, EXEC, DONE.
- IDLE: sample req_0 and req_1.
  - If neither is high, stay in IDLE.
  - Otherwise select a winner (see Configuration).
  - Capture the winner's op, size_sel, a and b into holding registers and record the owner.
  - Set grant_owner for the next cycle, clear the counter, and go to EXEC.
- EXEC: the dp_* outputs are driven from the holding registers, and are stable throughout EXEC and DONE.
  - The counter increments each cycle.
  - In the EXEC_CYCLES-th EXEC cycle, load result_owner from dp_result and go to DONE.
- DONE: done_owner is high for this single cycle, then go to IDLE.
- Requests are sampled only in IDLE. The requester must drop req by its done cycle; req still high in the following IDLE is a new job.
- Operands may change freely once grant is seen.
- The result register of the non-owning requester is never written.
- Reset values:
  - state = IDLE; busy, grant_x and done_x = 0.
  - result_x, holding registers, dp_matrix_a, dp_matrix_b and dp_operation = 0.
  - dp_size = 3 and dp_factor = 0.
  - Round-robin pointer favours requester 0.
- Reset asserted mid-job abandons the job: no done pulse, and the result registers are cleared.

## Timing
- req high in IDLE cycle t: grant at t+1, EXEC covers t+1 .. t+EXEC_CYCLES, done and result at t+EXEC_CYCLES+1, IDLE at t+EXEC_CYCLES+2.
- Back-to-back throughput is one job per EXEC_CYCLES+2 cycles.
- With default EXEC_CYCLES = 8: grant at t+1, done at t+9.
- A request arriving while busy waits with no loss, provided req is held; it is arbitrated in the next IDLE.
- grant and done are never high in the same cycle. At most one grant_x and at most one done_x are high in any cycle.

## Configuration
- MPU_SCHED_RR_EN defined: round-robin arbitration.
  - On simultaneous requests, the requester not served last wins.
  - The pointer updates on each grant.
  - A lone requester always wins.
- MPU_SCHED_RR_EN undefined: fixed priority; requester 0 always wins ties, and there is no pointer register.

## Test plan
- Single request: req_0 = 1, op_0 = 3'd0, size_sel_0 = 1, A = B = 200'h01 repeating bytes, dp_result stubbed to A+B.
  - Expect grant_0 at t+1 and done_0 at t+9.
  - Expect result_0 = bytes 0x02, and dp_size = 2.
  - grant_1, done_1 and result_1 stay 0.
- Simultaneous requests, RR_EN defined: req_0 and req_1 both held.
  - Expect grants in the order 0, 1, 0, with jobs spaced 10 cycles apart.
  - Without the macro: 0, 0, 0 while req_0 stays high.
- Operand capture: change a_0 to all-ones the cycle after grant_0.
  - dp_matrix_a keeps the original value; result_0 reflects the original operands.
- Request while busy: req_1 rises during requester 0's EXEC.
  - grant_1 comes exactly 2 cycles after done_0; done_1 comes 8 cycles after that.
- Reset mid-job: pull reset_n low in the 4th EXEC cycle.
  - busy, grants and dones are 0 immediately (asynchronous), and result_0 = 0.
  - After release with no req, the block stays in IDLE.
- Factor/size mapping: size_sel_1 = 0, b_1[7:0] = 8'hFD.
  - During EXEC, dp_size = 3 and dp_factor = 8'hFD.

Source files
------------

// File: rtl/mpu_op_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : mpu_op_scheduler
// Purpose  : Two-requester arbiter/sequencer sharing one matrix-ops datapath.
//            Optional round-robin arbitration: define MPU_SCHED_RR_EN.
// Revision : 1.0 - initial release
// ============================================================================
module mpu_op_scheduler #(
    parameter int N_BITS      = 200,
    parameter int EXEC_CYCLES = 8
) (
    input  logic              clock,
    input  logic              reset_n,

    input  logic              req_0,
    input  logic [2:0]        op_0,
    input  logic              size_sel_0,
    input  logic [N_BITS-1:0] a_0,
    input  logic [N_BITS-1:0] b_0,

    input  logic              req_1,
    input  logic [2:0]        op_1,
    input  logic              size_sel_1,
    input  logic [N_BITS-1:0] a_1,
    input  logic [N_BITS-1:0] b_1,

    output logic              grant_0,
    output logic              grant_1,
    output logic              done_0,
    output logic              done_1,
    output logic [N_BITS-1:0] result_0,
    output logic [N_BITS-1:0] result_1,
    output logic              busy,

    output logic [2:0]        dp_operation,
    output logic [N_BITS-1:0] dp_matrix_a,
    output logic [N_BITS-1:0] dp_matrix_b,
    output logic [7:0]        dp_size,
    output logic [7:0]        dp_factor,
    input  logic [N_BITS-1:0] dp_result
);

    localparam logic [1:0] c_IDLE     = 2'd0;
    localparam logic [1:0] c_EXEC     = 2'd1;
    localparam logic [1:0] c_DONE     = 2'd2;
    localparam logic [7:0] c_LAST_CNT = 8'(EXEC_CYCLES - 1);

    logic [1:0]        r_state;
    logic [7:0]        r_cnt;
    logic              r_owner;
    logic [2:0]        r_op;
    logic              r_size_sel;
    logic [N_BITS-1:0] r_a;
    logic [N_BITS-1:0] r_b;
    logic [N_BITS-1:0] r_result_0;
    logic [N_BITS-1:0] r_result_1;
    logic              r_grant_0;
    logic              r_grant_1;
    logic              r_done_0;
    logic              r_done_1;

    logic              w_any_req;
    logic              w_winner;
    logic              w_start;

    assign w_any_req = req_0 | req_1;
    assign w_start   = (r_state == c_IDLE) && w_any_req;

`ifdef MPU_SCHED_RR_EN
    // Requester preferred on the next tie; flips away from whoever was just served.
    logic r_favour;

    always_comb begin
        w_winner = ~req_0;
        if (req_0 && req_1) begin
            w_winner = r_favour;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_favour <= 1'b0;
        end else if (w_start) begin
            r_favour <= ~w_winner;
        end
    end
`else
    assign w_winner = ~req_0;
`endif

    // Operand holding registers; only loaded when a job is accepted.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_owner    <= 1'b0;
            r_op       <= 3'd0;
            r_size_sel <= 1'b0;
            r_a        <= '0;
            r_b        <= '0;
        end else if (w_start) begin
            r_owner    <= w_winner;
            r_op       <= w_winner ? op_1       : op_0;
            r_size_sel <= w_winner ? size_sel_1 : size_sel_0;
            r_a        <= w_winner ? a_1        : a_0;
            r_b        <= w_winner ? b_1        : b_0;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state    <= c_IDLE;
            r_cnt      <= 8'd0;
            r_grant_0  <= 1'b0;
            r_grant_1  <= 1'b0;
            r_done_0   <= 1'b0;
            r_done_1   <= 1'b0;
            r_result_0 <= '0;
            r_result_1 <= '0;
        end else begin
            r_grant_0 <= 1'b0;
            r_grant_1 <= 1'b0;
            r_done_0  <= 1'b0;
            r_done_1  <= 1'b0;
            case (r_state)
                c_IDLE: begin
                    if (w_any_req) begin
                        r_grant_0 <= ~w_winner;
                        r_grant_1 <= w_winner;
                        r_cnt     <= 8'd0;
                        r_state   <= c_EXEC;
                    end
                end
                c_EXEC: begin
                    r_cnt <= r_cnt + 8'd1;
                    // Counter holds (cycle index - 1), so this is the final EXEC cycle.
                    if (r_cnt == c_LAST_CNT) begin
                        if (r_owner) begin
                            r_result_1 <= dp_result;
                        end else begin
                            r_result_0 <= dp_result;
                        end
                        r_done_0 <= ~r_owner;
                        r_done_1 <= r_owner;
                        r_state  <= c_DONE;
                    end
                end
                c_DONE: begin
                    r_state <= c_IDLE;
                end
                default: begin
                    r_state <= c_IDLE;
                end
            endcase
        end
    end

    assign grant_0      = r_grant_0;
    assign grant_1      = r_grant_1;
    assign done_0       = r_done_0;
    assign done_1       = r_done_1;
    assign result_0     = r_result_0;
    assign result_1     = r_result_1;
    assign busy         = (r_state != c_IDLE);

    assign dp_operation = r_op;
    assign dp_matrix_a  = r_a;
    assign dp_matrix_b  = r_b;
    assign dp_size      = r_size_sel ? 8'd2 : 8'd3;
    assign dp_factor    = r_b[7:0];

endmodule
`default_nettype wire
